// File: rtl/mul_7r_seq_pkg.sv
// mul_7r_seq_pkg: shared FSM state encoding and sizing constants for the 7x7 shift-add multiplier.
package mul_7r_seq_pkg;
   localparam int ITER  = 7;
   localparam int CNT_W = 3;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;
endpackage

// File: rtl/sum_7r.sv
// sum_7r: 7-bit ripple-carry adder.
//   Ain, Bin : addends
//   Ci       : carry in
//   Sout     : sum
//   Co       : carry out of the top bit
module sum_7r
   import mul_7r_seq_pkg::*;
(
   input  logic [ITER-1:0] Ain,
   input  logic [ITER-1:0] Bin,
   input  logic            Ci,
   output logic [ITER-1:0] Sout,
   output logic            Co
);
   logic [ITER:0] c;
   assign c[0] = Ci;
   for (genvar i = 0; i < ITER; i++) begin : g_bit
      assign Sout[i]  = Ain[i] ^ Bin[i] ^ c[i];
      assign c[i+1]   = (Ain[i] & Bin[i]) | (c[i] & (Ain[i] ^ Bin[i]));
   end
   assign Co = c[ITER];
endmodule

// File: rtl/mul_7r_seq.sv
// mul_7r_seq: sequential 7x7 unsigned shift-add multiplier around one sum_7r adder.
//   clk, rst : clock, synchronous active-high reset
//   Start    : request a multiply (sampled only in IDLE)
//   Ain, Bin : multiplicand, multiplier (latched on the accepting edge)
//   Busy     : high during the 7 RUN cycles
//   Done     : one-cycle pulse when Prod is updated
//   Prod     : registered 14-bit product, held until the next result
module mul_7r_seq
   import mul_7r_seq_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          Start,
   input  logic [6:0]    Ain,
   input  logic [6:0]    Bin,
   output logic          Busy,
   output logic          Done,
   output logic [13:0]   Prod
);
   state_t           st;
   logic [6:0]       mc;
   logic [13:0]      p;
   logic [13:0]      p_nx;
   logic [CNT_W-1:0] cnt;
   logic [6:0]       s;
   logic             co;
   sum_7r u_sum (
      .Ain  (p[13:7]),
      .Bin  (mc),
      .Ci   (1'b0),
      .Sout (s),
      .Co   (co)
   );
   // multiplier bit p[0] selects add-then-shift or plain shift; carry lands in p[13]
   assign p_nx = p[0] ? {co, s, p[6:1]} : {1'b0, p[13:7], p[6:1]};
   assign Busy = st == ST_RUN;
   assign Done = st == ST_DONE;
   always_ff @(posedge clk) begin
      if (rst) begin
         st   <= ST_IDLE;
         mc   <= '0;
         p    <= '0;
         cnt  <= '0;
         Prod <= '0;
      end else begin
         case (st)
            ST_IDLE: if (Start) begin
               mc  <= Ain;
               p   <= {7'b0, Bin};
               cnt <= '0;
               st  <= ST_RUN;
            end
            ST_RUN: begin
               p   <= p_nx;
               cnt <= cnt + 1'b1;
               if (cnt == CNT_W'(ITER - 1)) begin
                  Prod <= p_nx;
                  st   <= ST_DONE;
               end
            end
            default: st <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mul_7r_seq.sv
// tb_mul_7r_seq: self-checking bench for mul_7r_seq (vector table, random ops, handshake corner cases).
module tb_mul_7r_seq;
   logic        clk = 0;
   logic        rst = 1;
   logic        Start = 0;
   logic [6:0]  Ain = 0;
   logic [6:0]  Bin = 0;
   logic        Busy;
   logic        Done;
   logic [13:0] Prod;
   int total = 0;
   int bad = 0;
   int last = 0;
   typedef struct {
      int a;
      int b;
      int p;
   } vec_t;
   vec_t vt[6];
   always #5 clk = ~clk;
   mul_7r_seq dut (
      .clk   (clk),
      .rst   (rst),
      .Start (Start),
      .Ain   (Ain),
      .Bin   (Bin),
      .Busy  (Busy),
      .Done  (Done),
      .Prod  (Prod)
   );
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask
   // Starts one multiply from IDLE and checks the full 9-cycle handshake.
   // With junk set, Start/Ain/Bin are randomised while the op is in flight.
   task automatic run_op(input int a, input int b, input int exp, input bit junk);
      Start = 1;
      Ain = 7'(a);
      Bin = 7'(b);
      tick();
      for (int c = 1; c <= 7; c++) begin
         Start = junk ? 1'($urandom) : 1'b0;
         Ain = junk ? 7'($urandom) : 7'd0;
         Bin = junk ? 7'($urandom) : 7'd0;
         chk("busy_run", Busy, 1);
         chk("done_run", Done, 0);
         chk("prod_hold", Prod, last);
         tick();
      end
      chk("done_pulse", Done, 1);
      chk("busy_done", Busy, 0);
      chk("prod", Prod, exp);
      Start = 0;
      tick();
      chk("done_once", Done, 0);
      chk("busy_idle", Busy, 0);
      last = exp;
   endtask
   initial begin
      int dn;
      int prev_c;
      vt[0] = '{5, 3, 15};
      vt[1] = '{127, 127, 16129};
      vt[2] = '{0, 85, 0};
      vt[3] = '{85, 0, 0};
      vt[4] = '{1, 127, 127};
      vt[5] = '{127, 1, 127};
      tick();
      tick();
      chk("rst_busy", Busy, 0);
      chk("rst_done", Done, 0);
      chk("rst_prod", Prod, 0);
      rst = 0;
      tick();
      chk("idle_busy", Busy, 0);
      for (int i = 0; i < 6; i++) run_op(vt[i].a, vt[i].b, vt[i].p, 0);
      for (int i = 0; i < 20; i++) begin
         int a = int'($urandom_range(0, 127));
         int b = int'($urandom_range(0, 127));
         run_op(a, b, a * b, i[0]);
      end
      Start = 1; Ain = 7'd10; Bin = 7'd12;
      tick();
      dn = 0;
      for (int c = 1; c <= 20; c++) begin
         Start = (c == 3 || c == 8);
         Ain = Start ? 7'd1 : 7'd10;
         Bin = Start ? 7'd1 : 7'd12;
         if (Done) begin
            dn++;
            chk("ign_done_cycle", c, 8);
            chk("ign_prod", Prod, 120);
         end
         tick();
      end
      Start = 0;
      chk("ign_done_count", dn, 1);
      chk("ign_prod_end", Prod, 120);
      last = 120;
      Start = 1; Ain = 7'd33; Bin = 7'd44;
      tick();
      Start = 0;
      tick(); tick(); tick();
      rst = 1;
      tick();
      rst = 0;
      chk("abort_busy", Busy, 0);
      chk("abort_done", Done, 0);
      chk("abort_prod", Prod, 0);
      dn = 0;
      for (int c = 0; c < 8; c++) begin
         dn += Done + Busy;
         tick();
      end
      chk("abort_quiet", dn, 0);
      last = 0;
      run_op(21, 6, 126, 0);
      Start = 1; Ain = 7'd9; Bin = 7'd7;
      dn = 0;
      prev_c = 0;
      for (int c = 0; c <= 35; c++) begin
         if (Done) begin
            dn++;
            chk("held_period", c - prev_c, (dn == 1) ? 8 : 9);
            prev_c = c;
         end
         if (dn > 0) chk("held_prod", Prod, 63);
         if (c == 35) Start = 0;
         tick();
      end
      chk("held_count", dn, 4);
      chk("held_idle", Busy, 0);
      chk("held_prod_end", Prod, 63);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
